// File: rtl/archie_wb_pkg.sv
// Shared Wishbone B3 definitions for the Archimedes-side bus responders.
// Cycle-type codes and the responder FSM state type.
package archie_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {IDLE, WAIT, SINGLE, BURST} wb_rsp_state_t;

endpackage

// File: rtl/wb_bram_be.sv
// Single-port 32-bit synchronous RAM with per-byte write enables and a 1-cycle read.
// The read register only updates on rd_en so the bus data holds between acks.
module wb_bram_be #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   input  logic              rd_en,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk_sys) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) rdata <= '0;
      else if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/wb_burst_ram_responder.sv
// Wishbone B3 registered-feedback responder for a local block RAM.
// Serves classic cycles and linear incrementing bursts with optional leading wait states.
module wb_burst_ram_responder
   import archie_wb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 14,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [3:0]        wb_sel,
   input  logic [ADDR_W-1:0] wb_adr,
   input  logic [31:0]       wb_dat_i,
   input  logic [2:0]        wb_cti,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);

   wb_rsp_state_t     state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_inc;
   logic              ack_q;
   logic              req;
   logic              commit;
   logic              cti_incr;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic              ram_rd;

   assign req      = wb_cyc & wb_stb;
   assign commit   = ack_q & req;
   assign cti_incr = (wb_cti == CTI_INCR);
   assign addr_inc = addr + ADDR_W'(1);
   assign wb_ack   = ack_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         ack_q <= 1'b0;
         cnt   <= '0;
         addr  <= '0;
      end else if (!wb_cyc) begin
         state <= IDLE;
         ack_q <= 1'b0;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (wb_stb) begin
                  addr <= wb_adr;
                  if (HAS_WAIT) begin
                     state <= WAIT;
                     cnt   <= WAIT_INIT;
                  end else begin
                     state <= cti_incr ? BURST : SINGLE;
                     ack_q <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (cnt <= 4'd1) begin
                  cnt <= '0;
                  if (wb_stb) begin
                     state <= cti_incr ? BURST : SINGLE;
                     ack_q <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            SINGLE: begin
               state <= IDLE;
               ack_q <= 1'b0;
            end
            BURST: begin
               if (ack_q) begin
                  if (wb_stb) begin
                     addr <= addr_inc;
                     if (!cti_incr) begin
                        state <= IDLE;
                        ack_q <= 1'b0;
                     end
                  end else begin
                     // Master stall: hold the beat address, resume on the next strobe.
                     ack_q <= 1'b0;
                  end
               end else if (wb_stb) begin
                  ack_q <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ack_q <= 1'b0;
            end
         endcase
      end
   end

   // Read commits inside a burst prefetch the next word so acks run back to back.
   always_comb begin
      ram_addr = addr;
      if (state == IDLE) ram_addr = wb_adr;
      else if (state == BURST && ack_q && !wb_we) ram_addr = addr_inc;
   end

   assign ram_we = commit & wb_we;
   assign ram_rd = req & ~wb_we &
                   (((state == IDLE) && !HAS_WAIT) ||
                    ((state == WAIT) && (cnt == 4'd1)) ||
                    ((state == BURST) && (!ack_q || cti_incr)));

   wb_bram_be #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .addr    (ram_addr),
      .we      (ram_we),
      .be      (wb_sel),
      .wdata   (wb_dat_i),
      .rd_en   (ram_rd),
      .rdata   (wb_dat_o)
   );

endmodule

// File: tb/tb_wb_burst_ram_responder.sv
// Scoreboarded bench: instance 0 (ADDR_W=14, no waits), instance 1 (ADDR_W=4, 3 waits).
// A word-array memory model supplies expected read data; a negedge monitor compares.
module tb_wb_burst_ram_responder;

   logic             clk;
   logic [1:0]       rst_n, cyc, stb, we, ack;
   logic [1:0][3:0]  sel;
   logic [1:0][13:0] adr;
   logic [1:0][31:0] dati, dato;
   logic [1:0][2:0]  cti;

   logic [31:0] model [2][16384];
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   logic [31:0] wdata [8];
   int          errors = 0;
   int          checks = 0;

   wb_burst_ram_responder #(.ADDR_W(14), .WAIT_CYCLES(0)) dut0 (
      .clk_sys (clk), .reset_n (rst_n[0]), .wb_cyc (cyc[0]), .wb_stb (stb[0]),
      .wb_we (we[0]), .wb_sel (sel[0]), .wb_adr (adr[0]), .wb_dat_i (dati[0]),
      .wb_cti (cti[0]), .wb_dat_o (dato[0]), .wb_ack (ack[0])
   );

   wb_burst_ram_responder #(.ADDR_W(4), .WAIT_CYCLES(3)) dut1 (
      .clk_sys (clk), .reset_n (rst_n[1]), .wb_cyc (cyc[1]), .wb_stb (stb[1]),
      .wb_we (we[1]), .wb_sel (sel[1]), .wb_adr (adr[1][3:0]), .wb_dat_i (dati[1]),
      .wb_cti (cti[1]), .wb_dat_o (dato[1]), .wb_ack (ack[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mask(input int p);
      return (p == 0) ? 16383 : 15;
   endfunction

   function automatic int waits(input int p);
      return (p == 0) ? 0 : 3;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every committed read beat must match the oldest expected word.
   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (rst_n[p] && ack[p] && cyc[p] && stb[p] && !we[p]) begin
            if (p == 0 && exp0.size() == 0 || p == 1 && exp1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: inst %0d acked a read with nothing expected", p);
            end else if (p == 0) begin
               chk("rd_data0", dato[0], exp0.pop_front());
            end else begin
               chk("rd_data1", dato[1], exp1.pop_front());
            end
         end
      end
   end

   // Master: one classic cycle (n==1) or n-beat incrementing burst; starts at posedge+1.
   task automatic xfer(input int p, input bit w, input int base, input int n,
                       input logic [3:0] s, input bit stall, input int stop_after,
                       output int cycles);
      int   i, a;
      bit   acked, pushed;
      logic [2:0] lastc, clc;
      lastc  = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'b000;
      clc    = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b001;
      cycles = 0;
      i      = 0;
      pushed = 0;
      while (i < n) begin
         a       = (base + i) & mask(p);
         cyc[p]  = 1'b1;
         stb[p]  = 1'b1;
         we[p]   = w;
         adr[p]  = 14'(a);
         sel[p]  = s;
         dati[p] = wdata[i];
         cti[p]  = (n == 1) ? clc : ((i < n - 1) ? 3'b010 : lastc);
         if (!w && !pushed) begin
            if (p == 0) exp0.push_back(model[0][a]);
            else exp1.push_back(model[1][a]);
            pushed = 1;
         end
         @(negedge clk);
         cycles++;
         acked = ack[p];
         @(posedge clk);
         #1;
         if (acked) begin
            if (w) model[p][a] = merge(model[p][a], wdata[i], s);
            i++;
            pushed = 0;
            if (i == stop_after) return;
            if (stall && i < n && $urandom_range(0, 3) == 0) begin
               stb[p] = 1'b0;
               @(negedge clk);
               cycles++;
               @(posedge clk);
               #1;
            end
         end
         if (cycles > 60) begin
            checks++;
            errors++;
            $display("FAIL timeout: inst %0d beat %0d got no ack, required one", p, i);
            break;
         end
      end
      cyc[p] = 1'b0;
      stb[p] = 1'b0;
   endtask

   task automatic single_wr(input int p, input int a, input logic [31:0] d);
      int c;
      wdata[0] = d;
      xfer(p, 1'b1, a, 1, 4'hF, 1'b0, -1, c);
   endtask

   task automatic single_rd(input int p, input int a);
      int c;
      xfer(p, 1'b0, a, 1, 4'(($urandom)), 1'b0, -1, c);
   endtask

   initial begin
      int  c;
      bit  saw_ack;
      rst_n = '0; cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dati = '0; cti = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ack0", 32'(ack[0]), 0);
      chk("reset_dat0", dato[0], 0);
      chk("reset_ack1", 32'(ack[1]), 0);
      chk("reset_dat1", dato[1], 0);
      @(posedge clk);
      #1;
      rst_n = 2'b11;
      @(posedge clk);
      #1;

      for (int a = 0; a < 16; a++) single_wr(1, a, $urandom);
      for (int a = 'h80; a < 'hA0; a++) single_wr(0, a, $urandom);

      // Classic write/read with latency and ack width.
      wdata[0] = 32'hDEADBEEF;
      xfer(0, 1'b1, 'h10, 1, 4'hF, 1'b0, -1, c);
      chk("wr_latency", c, 2);
      xfer(0, 1'b0, 'h10, 1, 4'hF, 1'b0, -1, c);
      chk("rd_latency", c, 2);
      @(negedge clk);
      chk("ack_width", 32'(ack[0]), 0);
      @(posedge clk);
      #1;

      // Byte lanes 0 and 2 only.
      wdata[0] = 32'h11223344;
      xfer(0, 1'b1, 'h10, 1, 4'b0101, 1'b0, -1, c);
      single_rd(0, 'h10);

      // Four-beat read burst of 0..3.
      for (int a = 0; a < 4; a++) single_wr(0, 'h20 + a, 32'(a));
      xfer(0, 1'b0, 'h20, 4, 4'hF, 1'b0, -1, c);
      chk("burst_cycles", c, 5);
      @(negedge clk);
      chk("burst_ack_end", 32'(ack[0]), 0);
      @(posedge clk);
      #1;

      // Wrap at the top word of a 16-word RAM.
      wdata[0] = 32'hA5A5_0001;
      wdata[1] = 32'hB6B6_0002;
      xfer(1, 1'b1, 'hF, 2, 4'hF, 1'b0, -1, c);
      chk("wrap_wr_cycles", c, 1 + waits(1) + 2);
      single_rd(1, 'hF);
      single_rd(1, 'h0);
      xfer(1, 1'b0, 'hF, 2, 4'hF, 1'b0, -1, c);

      // Wait states, then an abandoned cycle, then a normal one.
      single_rd(1, 5);
      xfer(1, 1'b0, 5, 1, 4'hF, 1'b0, -1, c);
      chk("wait_latency", c, 1 + waits(1) + 1);
      exp1.push_back(model[1][5]);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 14'd5; cti[1] = 3'b000;
      saw_ack = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin
            cyc[1] = 1'b0;
            stb[1] = 1'b0;
         end
         @(negedge clk);
         if (ack[1]) saw_ack = 1;
         @(posedge clk);
         #1;
      end
      void'(exp1.pop_back());
      chk("abort_no_ack", 32'(saw_ack), 0);
      xfer(1, 1'b0, 5, 1, 4'hF, 1'b0, -1, c);
      chk("after_abort_latency", c, 1 + waits(1) + 1);

      // Reset pulse after three beats of an eight-beat write burst.
      for (int a = 0; a < 8; a++) single_wr(0, 'h40 + a, $urandom);
      for (int k = 0; k < 8; k++) wdata[k] = $urandom;
      xfer(0, 1'b1, 'h40, 8, 4'hF, 1'b0, 3, c);
      chk("pre_reset_ack", 32'(ack[0]), 1);
      rst_n[0] = 1'b0;
      #1;
      chk("reset_ack_now", 32'(ack[0]), 0);
      chk("reset_dat_now", dato[0], 0);
      cyc[0] = 1'b0;
      stb[0] = 1'b0;
      @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      @(posedge clk);
      #1;
      for (int a = 0; a < 8; a++) single_rd(0, 'h40 + a);

      // Random traffic with stalls on both instances.
      for (int p = 0; p < 2; p++) begin
         for (int t = 0; t < 40; t++) begin
            int n, base;
            n    = $urandom_range(1, 5);
            base = (p == 0) ? ('h80 + $urandom_range(0, 27)) : $urandom_range(0, 15);
            for (int k = 0; k < 8; k++) wdata[k] = $urandom;
            xfer(p, 1'($urandom_range(0, 1)), base, n, 4'($urandom), 1'b1, -1, c);
         end
      end

      repeat (4) @(posedge clk);
      chk("sb_drain0", exp0.size(), 0);
      chk("sb_drain1", exp1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
